// File: rtl/lutram_fifo_ctrl_pkg.sv
// Shared helpers for the LUT-RAM FIFO controller: log2 and parameter legality.
package lutram_fifo_ctrl_pkg;

    function automatic int log2Ceil(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic bit isPow2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit fifoParamsOk(input int depth, input int addrWidth,
                                        input int almostFull, input int almostEmpty);
        return isPow2(depth)
            && (addrWidth == log2Ceil(depth))
            && (almostFull >= 0) && (almostFull <= depth)
            && (almostEmpty >= 0) && (almostEmpty <= depth);
    endfunction

endpackage

// File: rtl/lutram_fifo_ctrl_lutram.sv
// Zero-latency LUT-RAM: synchronous write, combinational read.
module LutRam #(
    parameter int pBitWidth  = 8,
    parameter int pAddrWidth = 4
) (
    input  logic                  iCLK,
    input  logic                  iWE,
    input  logic [pAddrWidth-1:0] iWA,
    input  logic [pBitWidth-1:0]  iWD,
    input  logic [pAddrWidth-1:0] iRA,
    output logic [pBitWidth-1:0]  oRD
);

    logic [pBitWidth-1:0] mem [0:(1 << pAddrWidth)-1];

    // Store the write word at the write address; no reset on contents.
    always_ff @(posedge iCLK) begin
        if (iWE) begin
            mem[iWA] <= iWD;
        end
    end

    assign oRD = mem[iRA];

endmodule

// File: rtl/lutram_fifo_ctrl.sv
// First-word-fall-through FIFO controller around LutRam. Owns the pointers,
// the occupancy count, the registered full/empty/threshold flags and the
// sticky overflow/underflow flags.
module lutram_fifo_ctrl
    import lutram_fifo_ctrl_pkg::*;
#(
    parameter int pBuffDepth   = 16,
    parameter int pBitWidth    = 8,
    parameter int pAddrWidth   = 4,
    parameter int pAlmostFull  = 12,
    parameter int pAlmostEmpty = 2
) (
    input  logic                  iCLK,
    input  logic                  iRST_n,
    input  logic                  iCLR,
    input  logic [pBitWidth-1:0]  iWD,
    input  logic                  iWE,
    output logic                  oFULL,
    output logic                  oAFULL,
    input  logic                  iRE,
    output logic [pBitWidth-1:0]  oRD,
    output logic                  oRVD,
    output logic                  oAEMPTY,
    output logic [pAddrWidth:0]   oCOUNT,
    output logic                  oOVF,
    output logic                  oUDF
);

    if (!fifoParamsOk(pBuffDepth, pAddrWidth, pAlmostFull, pAlmostEmpty)) begin : gBadParams
        $error("lutram_fifo_ctrl: illegal depth / address width / threshold combination");
    end

    localparam logic [pAddrWidth:0]   cDepth   = pBuffDepth[pAddrWidth:0];
    localparam logic [pAddrWidth:0]   cAFull   = pAlmostFull[pAddrWidth:0];
    localparam logic [pAddrWidth:0]   cAEmpty  = pAlmostEmpty[pAddrWidth:0];
    localparam logic [pAddrWidth:0]   cZeroCnt = '0;
    localparam logic [pAddrWidth:0]   cOneCnt  = {{pAddrWidth{1'b0}}, 1'b1};
    localparam logic [pAddrWidth-1:0] cOnePtr  = {{(pAddrWidth-1){1'b0}}, 1'b1};

    logic [pAddrWidth-1:0] wrPtr;
    logic [pAddrWidth-1:0] rdPtr;
    logic [pAddrWidth:0]   count;
    logic [pAddrWidth:0]   countNext;
    logic                  wrAcc;
    logic                  rdAcc;
    logic                  flush;
    logic                  ramWe;

    // Accept decode uses only registered flags, so nothing is combinational
    // from the requests to oFULL/oRVD.
    assign wrAcc = iWE & ~oFULL;
    assign rdAcc = iRE & oRVD;
    assign flush = ~iRST_n | iCLR;
    // A flush cycle must not disturb RAM contents either.
    assign ramWe = wrAcc & ~flush;

    // Next occupancy for the normal (non-flush) case; flags are derived from it.
    always_comb begin
        countNext = count;
        case ({wrAcc, rdAcc})
            2'b10:   countNext = count + cOneCnt;
            2'b01:   countNext = count - cOneCnt;
            default: countNext = count;
        endcase
    end

    // Pointers, count, flags and sticky errors; reset and flush zero everything.
    always_ff @(posedge iCLK) begin
        if (!iRST_n || iCLR) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
            oFULL   <= 1'b0;
            oAFULL  <= (cZeroCnt >= cAFull);
            oRVD    <= 1'b0;
            oAEMPTY <= 1'b1;
            oOVF    <= 1'b0;
            oUDF    <= 1'b0;
        end else begin
            if (wrAcc) begin
                wrPtr <= wrPtr + cOnePtr;
            end
            if (rdAcc) begin
                rdPtr <= rdPtr + cOnePtr;
            end
            count   <= countNext;
            oFULL   <= (countNext == cDepth);
            oAFULL  <= (countNext >= cAFull);
            oRVD    <= (countNext != cZeroCnt);
            oAEMPTY <= (countNext <= cAEmpty);
            if (iWE && oFULL) begin
                oOVF <= 1'b1;
            end
            if (iRE && !oRVD) begin
                oUDF <= 1'b1;
            end
        end
    end

    assign oCOUNT = count;

    LutRam #(
        .pBitWidth (pBitWidth),
        .pAddrWidth(pAddrWidth)
    ) uLutRam (
        .iCLK(iCLK),
        .iWE (ramWe),
        .iWA (wrPtr),
        .iWD (iWD),
        .iRA (rdPtr),
        .oRD (oRD)
    );

endmodule

// File: tb/tb_lutram_fifo_ctrl.sv
// Bench for lutram_fifo_ctrl at depth 4: directed stimulus pushes expected
// head words into a queue, a negedge monitor pops and compares on each pop.
module tb_lutram_fifo_ctrl;

    logic       iCLK;
    logic       iRST_n;
    logic       iCLR;
    logic [7:0] iWD;
    logic       iWE;
    logic       oFULL;
    logic       oAFULL;
    logic       iRE;
    logic [7:0] oRD;
    logic       oRVD;
    logic       oAEMPTY;
    logic [2:0] oCOUNT;
    logic       oOVF;
    logic       oUDF;

    int total = 0;
    int bad   = 0;
    logic [7:0] expQ [$];

    lutram_fifo_ctrl #(
        .pBuffDepth  (4),
        .pBitWidth   (8),
        .pAddrWidth  (2),
        .pAlmostFull (3),
        .pAlmostEmpty(1)
    ) dut (
        .iCLK   (iCLK),
        .iRST_n (iRST_n),
        .iCLR   (iCLR),
        .iWD    (iWD),
        .iWE    (iWE),
        .oFULL  (oFULL),
        .oAFULL (oAFULL),
        .iRE    (iRE),
        .oRD    (oRD),
        .oRVD   (oRVD),
        .oAEMPTY(oAEMPTY),
        .oCOUNT (oCOUNT),
        .oOVF   (oOVF),
        .oUDF   (oUDF)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, req, req, $time);
        end
    endtask

    // Expected flag/count snapshot after an edge.
    task automatic chkState(input string tag, input int cnt, input int full, input int afull,
                            input int rvd, input int aempty, input int ovf, input int udf);
        chk({tag, ".count"},  int'(oCOUNT),  cnt);
        chk({tag, ".full"},   int'(oFULL),   full);
        chk({tag, ".afull"},  int'(oAFULL),  afull);
        chk({tag, ".rvd"},    int'(oRVD),    rvd);
        chk({tag, ".aempty"}, int'(oAEMPTY), aempty);
        chk({tag, ".ovf"},    int'(oOVF),    ovf);
        chk({tag, ".udf"},    int'(oUDF),    udf);
    endtask

    // One clock with the given requests; returns #1 after the edge, requests idle.
    task automatic step(input logic we, input logic [7:0] wd, input logic re);
        iWE = we;
        iWD = wd;
        iRE = re;
        @(posedge iCLK);
        #1;
        iWE = 1'b0;
        iRE = 1'b0;
        iCLR = 1'b0;
        iRST_n = 1'b1;
    endtask

    task automatic wrPush(input logic [7:0] wd);
        expQ.push_back(wd);
        step(1'b1, wd, 1'b0);
    endtask

    // Monitor: a pop is accepted at the coming edge; the head word must match.
    always @(negedge iCLK) begin
        if (iRST_n && !iCLR && iRE && oRVD) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("FAIL popUnexpected: got 0x%0h expected no valid head at %0t", oRD, $time);
            end else begin
                chk("popData", int'(oRD), int'(expQ.pop_front()));
            end
        end
    end

    initial begin
        iRST_n = 1'b0;
        iCLR   = 1'b0;
        iWE    = 1'b0;
        iRE    = 1'b0;
        iWD    = 8'h00;
        @(posedge iCLK);
        #1;
        @(posedge iCLK);
        #1;
        iRST_n = 1'b1;
        chkState("reset", 0, 0, 0, 0, 1, 0, 0);

        // Fill then read back, with overflow on a 5th write
        wrPush(8'h11); chkState("fill1", 1, 0, 0, 1, 1, 0, 0);
        wrPush(8'h22); chkState("fill2", 2, 0, 0, 1, 0, 0, 0);
        wrPush(8'h33); chkState("fill3", 3, 0, 1, 1, 0, 0, 0);
        wrPush(8'h44); chkState("fill4", 4, 1, 1, 1, 0, 0, 0);
        step(1'b1, 8'h55, 1'b0);
        chkState("ovf", 4, 1, 1, 1, 0, 1, 0);
        step(1'b0, 8'h00, 1'b1); chkState("rd1", 3, 0, 1, 1, 0, 1, 0);
        step(1'b0, 8'h00, 1'b1); chkState("rd2", 2, 0, 0, 1, 0, 1, 0);
        step(1'b0, 8'h00, 1'b1); chkState("rd3", 1, 0, 0, 1, 1, 1, 0);
        step(1'b0, 8'h00, 1'b1); chkState("rd4", 0, 0, 0, 0, 1, 1, 0);
        step(1'b0, 8'h00, 1'b1);
        chkState("udf", 0, 0, 0, 0, 1, 1, 1);
        iCLR = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        chkState("clr", 0, 0, 0, 0, 1, 0, 0);

        // Empty write latency
        wrPush(8'hA5);
        chk("latency.rvd", int'(oRVD), 1);
        chk("latency.rd", int'(oRD), 8'hA5);
        step(1'b0, 8'h00, 1'b1);
        chkState("latencyPop", 0, 0, 0, 0, 1, 0, 0);

        // Simultaneous write and read at count 2
        wrPush(8'h01);
        wrPush(8'h02);
        expQ.push_back(8'h03);
        step(1'b1, 8'h03, 1'b1);
        chkState("sim2", 2, 0, 0, 1, 0, 0, 0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chkState("sim2Drain", 0, 0, 0, 0, 1, 0, 0);

        // Simultaneous at count 0: only the write lands, underflow flagged
        expQ.push_back(8'h77);
        step(1'b1, 8'h77, 1'b1);
        chkState("sim0", 1, 0, 0, 1, 1, 0, 1);
        step(1'b0, 8'h00, 1'b1);
        iCLR = 1'b1;
        step(1'b0, 8'h00, 1'b0);

        // Simultaneous at count 4: only the read lands, overflow flagged
        wrPush(8'hB1);
        wrPush(8'hB2);
        wrPush(8'hB3);
        wrPush(8'hB4);
        step(1'b1, 8'h99, 1'b1);
        chkState("sim4", 3, 0, 1, 1, 0, 1, 0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chkState("sim4Drain", 0, 0, 0, 0, 1, 1, 0);
        iCLR = 1'b1;
        step(1'b0, 8'h00, 1'b0);

        // Pointer wrap: 10 words streamed through with overlapping pairs
        wrPush(8'h00);
        for (int i = 1; i < 10; i++) begin
            expQ.push_back(8'(i));
            step(1'b1, 8'(i), 1'b1);
            chk("wrap.count", int'(oCOUNT), 1);
        end
        step(1'b0, 8'h00, 1'b1);
        chkState("wrapDone", 0, 0, 0, 0, 1, 0, 0);

        // Reset in the middle of a stream
        wrPush(8'hC1);
        wrPush(8'hC2);
        wrPush(8'hC3);
        iRST_n = 1'b0;
        step(1'b1, 8'hC4, 1'b1);
        expQ.delete();
        chkState("midReset", 0, 0, 0, 0, 1, 0, 0);
        wrPush(8'h5A);
        chk("postReset.rd", int'(oRD), 8'h5A);
        step(1'b0, 8'h00, 1'b1);
        chkState("postReset", 0, 0, 0, 0, 1, 0, 0);

        chk("scoreboardEmpty", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lutram_fifo_ctrl.md
# lutram_fifo_ctrl

Synchronous first-word-fall-through (FWFT) FIFO controller around the zero-latency LUT-RAM primitive (`LutRam`). It owns the write/read pointers, occupancy count, full/empty and threshold flags, and the error and flush handling. It gives producer/consumer blocks (MIDI byte queues, command buffers) a single-clock queue whose head word is always visible on the output.

## Interface
Parameters:
- `pBuffDepth`, 16: number of entries; must be a power of two and ≥ 2.
- `pBitWidth`, 8: data width.
- `pAddrWidth`, 4: pointer width; must equal log2(`pBuffDepth`).
- `pAlmostFull`, 12: `oAFULL` asserts when count ≥ this value.
- `pAlmostEmpty`, 2: `oAEMPTY` asserts when count ≤ this value.

Ports:
- `iCLK`, in, 1: single clock. All logic is on the rising edge.
- `iRST_n`, in, 1: reset, synchronous and active-low.
- `iCLR`, in, 1: synchronous flush.
- `iWD`, in, `pBitWidth`: write data.
- `iWE`, in, 1: write request.
- `oFULL`, out, 1: FIFO full.
- `oAFULL`, out, 1: almost full.
- `iRE`, in, 1: read request (pop the head word).
- `oRD`, out, `pBitWidth`: head word, valid while `oRVD` = 1.
- `oRVD`, out, 1: head valid (equals not-empty).
- `oAEMPTY`, out, 1: almost empty.
- `oCOUNT`, out, `pAddrWidth+1`: occupancy, 0..`pBuffDepth`.
- `oOVF`, out, 1: sticky flag; set by a write request while full.
- `oUDF`, out, 1: sticky flag; set by a read request while empty.

## Operation
- **Write acceptance.** A write is accepted when `iWE` = 1 and `oFULL` = 0. The RAM write enable is driven at the write pointer, and the write pointer then increments. When full, the write is dropped and `oOVF` is set, even if `iRE` is asserted in the same cycle.
- **Read acceptance.** A read is accepted when `iRE` = 1 and `oRVD` = 1; the read pointer then increments. When empty, the read is ignored and `oUDF` is set.
- **Head word.** `oRD` is driven combinationally as RAM[rd_ptr]. When `oRVD` = 0, `oRD` has no defined value and is not checked.
- **Pointers.** Both pointers are `pAddrWidth` bits and wrap modulo `pBuffDepth` with no special case.
- **Count.** The count register is `pAddrWidth+1` bits:
  - +1 on a write-only accept;
  - −1 on a read-only accept;
  - unchanged when both are accepted or neither is.
- **Flags.** `oFULL` = (count == `pBuffDepth`), `oRVD` = (count != 0). The threshold flags compare against `pAlmostFull` and `pAlmostEmpty`. All flags are registered and computed from the next-count value, so they never lag the count.
- **Simultaneous write and read.**
  - On a non-empty, non-full FIFO: both are accepted and the count holds.
  - On an empty FIFO: only the write is accepted and `oUDF` is set.
- **Flush.** `iCLR` = 1 zeroes the pointers and count and clears `oOVF`/`oUDF`. It has priority over any `iWE`/`iRE` in the same cycle, and RAM contents are left unchanged.
- **Reset.** `iRST_n` = 0 has the same effect as `iCLR` and takes priority over it.

## Timing
- Reset values:
  - `oFULL` = 0, `oAFULL` = 0, `oRVD` = 0;
  - `oAEMPTY` = 1 (`pAlmostEmpty` ≥ 0);
  - `oCOUNT` = 0, `oOVF` = 0, `oUDF` = 0.
- Write-to-read latency is 1 cycle. A word written at edge N into an empty FIFO is on `oRD` with `oRVD` = 1 during cycle N+1.
- After a read accepted at edge N, the next word is on `oRD` during cycle N+1. There are no bubbles at one pop per cycle.
- Sustained throughput is 1 write + 1 read per cycle.
- `oFULL` and `oRVD` change only at clock edges, never combinationally from `iWE`/`iRE`.
- Reset or flush in the middle of a stream: the FIFO reads as empty in the cycle after the edge, and requests in the flush cycle have no effect.

## Structure
- A shared package holds the log2 helper function and the parameter legality checks (power-of-two depth, `pAddrWidth` consistency, thresholds ≤ `pBuffDepth`).
- The single sub-module is the existing `LutRam`, instantiated as `uLutRam` with `iWA` = wr_ptr, `iRA` = rd_ptr, `iWE` = accepted write.
- The remaining logic is accept decode, pointer/count registers, flag registers and sticky error registers.

## Test plan
All scenarios use `pBuffDepth` = 4, `pBitWidth` = 8, `pAlmostFull` = 3, `pAlmostEmpty` = 1.
- **Fill then read back.** Write 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
  - Required: `oCOUNT` steps 1→4; `oAFULL` rises at count 3; `oFULL` rises at count 4.
  - Then read 4 times: `oRD` = 0x11, 0x22, 0x33, 0x44; `oRVD` falls after the 4th read; `oAEMPTY` is 1 at count ≤ 1.
- **Empty write latency.** Write 0xA5 into an empty FIFO at edge N.
  - Required: `oRVD` = 1 and `oRD` = 0xA5 in cycle N+1.
- **Overflow and underflow.**
  - A 5th write while full: data dropped, `oOVF` = 1, count stays 4, FIFO contents unchanged.
  - A read while empty: `oUDF` = 1.
  - `iCLR` clears both flags.
- **Simultaneous write and read.**
  - At count 2: count stays 2 and the order is preserved.
  - At count 0: only the write is accepted and `oUDF` is set.
  - At count 4: only the read is accepted, count becomes 3, and `oOVF` is set.
- **Pointer wrap-around.** Run 10 interleaved write/read pairs with incrementing data 0x00..0x09.
  - Required: pointers wrap twice and the output sequence exactly matches the input.
- **Reset in the middle of a stream.** At count 3 with `iWE` = `iRE` = 1, assert `iRST_n` = 0 for one cycle.
  - Required: next cycle count = 0, `oRVD` = 0, `oFULL` = 0, flags cleared.
  - A following write of 0x5A appears first on `oRD`.
